// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants, FSM state type and origin helper for lcd_host
package lcd_pkg;

  localparam int IMG_W = 6;
  localparam int WIN   = 3;
  localparam int PIX_N = IMG_W * IMG_W;
  localparam int WIN_N = WIN * WIN;

  localparam logic [2:0] CMD_REFLASH = 3'd0;
  localparam logic [2:0] CMD_LOAD    = 3'd1;
  localparam logic [2:0] CMD_RIGHT   = 3'd2;
  localparam logic [2:0] CMD_LEFT    = 3'd3;
  localparam logic [2:0] CMD_UP      = 3'd4;
  localparam logic [2:0] CMD_DOWN    = 3'd5;

  localparam logic [1:0] ORG_LOAD = 2'd2;
  localparam logic [1:0] ORG_MAX  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_LOAD,
    ST_COLLECT,
    ST_DRAIN,
    ST_DELIVER
  } state_t;

  // One axis of the origin mirror: saturating step in either direction.
  function automatic logic [1:0] step_axis(input logic [1:0] v, input logic inc, input logic dec);
    if (inc && v != ORG_MAX) return v + 2'd1;
    if (dec && v != 2'd0)    return v - 2'd1;
    return v;
  endfunction

endpackage

// File: rtl/lcd_host_if.sv
// rtl/lcd_host_if.sv - request, pixel source, display controller and window delivery signals
interface lcd_host_if;
  import lcd_pkg::*;

  logic                 req_valid;
  logic [2:0]           req_cmd;
  logic                 req_ready;
  logic [5:0]           pix_addr;
  logic [7:0]           pix_data;
  logic [2:0]           cmd;
  logic                 cmd_valid;
  logic [7:0]           datain;
  logic                 busy;
  logic                 output_valid;
  logic [7:0]           dataout;
  logic                 win_valid;
  logic                 win_ready;
  logic [WIN_N*8-1:0]   win_data;
  logic [1:0]           win_x;
  logic [1:0]           win_y;
  logic                 err;

  modport master (
    input  req_valid, req_cmd, pix_data, busy, output_valid, dataout, win_ready,
    output req_ready, pix_addr, cmd, cmd_valid, datain, win_valid, win_data, win_x, win_y, err
  );

  modport slave (
    output req_valid, req_cmd, pix_data, busy, output_valid, dataout, win_ready,
    input  req_ready, pix_addr, cmd, cmd_valid, datain, win_valid, win_data, win_x, win_y, err
  );

endinterface

// File: rtl/lcd_win_buf.sv
// rtl/lcd_win_buf.sv - nine-slot byte capture buffer with slot counter and clear
module lcd_win_buf
  import lcd_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr_i,
  input  logic                 we_i,
  input  logic [7:0]           din_i,
  output logic [3:0]           cnt_o,
  output logic [WIN_N*8-1:0]   data_o
);

  logic [7:0] slot_q [WIN_N];
  logic [3:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      for (int i = 0; i < WIN_N; i++) slot_q[i] <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
      for (int i = 0; i < WIN_N; i++) slot_q[i] <= '0;
    end else if (we_i && cnt_q < 4'(WIN_N)) begin
      slot_q[cnt_q] <= din_i;
      cnt_q         <= cnt_q + 4'd1;
    end
  end

  for (genvar g = 0; g < WIN_N; g++) begin : g_pack
    assign data_o[g*8 +: 8] = slot_q[g];
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/lcd_host.sv
// rtl/lcd_host.sv - host sequencer: issues display commands, streams the image, captures a 3x3 window.
// Optional COLLECT/DRAIN watchdog enabled by defining LCD_HOST_TIMEOUT_EN.
module lcd_host
  import lcd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        reset,
  lcd_host_if.master  bus
);

  state_t       state_q, state_d;
  logic [2:0]   cmd_q, cmd_d;
  logic [1:0]   x_q, x_d, y_q, y_d;
  logic         err_q, err_d;
  logic [5:0]   load_q, load_d;

  logic               buf_clr, buf_we;
  logic [3:0]         buf_cnt;
  logic [WIN_N*8-1:0] buf_data;
  logic               abort;

  lcd_win_buf u_win_buf (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (buf_clr),
    .we_i   (buf_we),
    .din_i  (bus.dataout),
    .cnt_o  (buf_cnt),
    .data_o (buf_data)
  );

`ifdef LCD_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          busy_q;
  logic          wait_st, progress;

  assign wait_st  = (state_q == ST_COLLECT) || (state_q == ST_DRAIN);
  // A falling busy counts as progress so a slow controller is not aborted in DRAIN.
  assign progress = bus.output_valid || (busy_q && !bus.busy);
  assign abort    = wait_st && !progress && (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    tmo_d = '0;
    if (wait_st && !progress && !abort) tmo_d = tmo_q + TW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      tmo_q  <= tmo_d;
      busy_q <= bus.busy;
    end
  end
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    x_d     = x_q;
    y_d     = y_q;
    err_d   = err_q;
    load_d  = load_q;
    buf_clr = 1'b0;
    buf_we  = 1'b0;

    bus.req_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd       = '0;
    bus.pix_addr  = '0;
    bus.datain    = '0;
    bus.win_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (bus.req_cmd <= CMD_DOWN) begin
            cmd_d   = bus.req_cmd;
            err_d   = 1'b0;
            buf_clr = 1'b1;
            load_d  = '0;
            state_d = ST_ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_ISSUE: begin
        if (!bus.busy) begin
          bus.cmd_valid = 1'b1;
          bus.cmd       = cmd_q;
          if (cmd_q == CMD_LOAD) begin
            x_d = ORG_LOAD;
            y_d = ORG_LOAD;
          end else begin
            x_d = step_axis(x_q, cmd_q == CMD_RIGHT, cmd_q == CMD_LEFT);
            y_d = step_axis(y_q, cmd_q == CMD_DOWN,  cmd_q == CMD_UP);
          end
          state_d = (cmd_q == CMD_LOAD) ? ST_LOAD : ST_COLLECT;
        end
      end

      ST_LOAD: begin
        bus.pix_addr = load_q;
        bus.datain   = bus.pix_data;
        load_d       = load_q + 6'd1;
        if (load_q == 6'(PIX_N - 1)) state_d = ST_COLLECT;
      end

      ST_COLLECT: begin
        if (bus.output_valid) begin
          buf_we = 1'b1;
          if (buf_cnt == 4'(WIN_N - 1)) state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        // Any pixel beyond the ninth is a controller protocol error; drop it.
        if (bus.output_valid)  err_d   = 1'b1;
        else if (!bus.busy)    state_d = ST_DELIVER;
      end

      ST_DELIVER: begin
        bus.win_valid = 1'b1;
        if (bus.win_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_REFLASH;
      x_q     <= ORG_LOAD;
      y_q     <= ORG_LOAD;
      err_q   <= 1'b0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      x_q     <= x_d;
      y_q     <= y_d;
      err_q   <= err_d;
      load_q  <= load_d;
    end
  end

  assign bus.win_data = (state_q == ST_DELIVER) ? buf_data : '0;
  assign bus.win_x    = x_q;
  assign bus.win_y    = y_q;
  assign bus.err      = err_q;

endmodule
